// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared state encoding, command codes and size defaults for the SPI RAM slave
package spi_ram_pkg;
  localparam int MEM_DEPTH_DEF = 256;
  localparam int ADDR_SIZE_DEF = 8;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;
  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;
endpackage

// File: rtl/spi_slave_core.sv
// spi_slave_core: frame FSM, 10-bit receive shifter and MSB-first MISO serializer
module spi_slave_core
  import spi_ram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ss_n,
  input  logic       mosi,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       miso,
  output logic       rx_valid,
  output logic [9:0] rx_data
);
  state_t current_state, next_state;
  logic rd_addr_received;
  logic [3:0] bit_cnt, tx_cnt;
  logic [7:0] tx_sh;
  logic shifting, last_bit;
  assign shifting = !ss_n && current_state inside {WRITE, READ_ADD, READ_DATA} && bit_cnt < 4'd10;
  assign last_bit = shifting && bit_cnt == 4'd9;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) current_state <= IDLE;
    else current_state <= next_state;
  always_comb begin
    next_state = current_state;
    if (ss_n) next_state = IDLE;
    else if (current_state == IDLE) next_state = CHK_CMD;
    else if (current_state == CHK_CMD) next_state = !mosi ? WRITE : rd_addr_received ? READ_DATA : READ_ADD;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_data <= '0;
      rx_valid <= 1'b0;
      rd_addr_received <= 1'b0;
      bit_cnt <= '0;
      tx_cnt <= '0;
      tx_sh <= '0;
      miso <= 1'b0;
    end else begin
      rx_valid <= last_bit;
      if (ss_n) begin
        bit_cnt <= '0;
        tx_cnt <= '0;
        tx_sh <= '0;
        miso <= 1'b0;
      end else begin
        if (current_state == CHK_CMD) bit_cnt <= '0;
        else if (shifting) begin
          rx_data <= {rx_data[8:0], mosi};
          bit_cnt <= bit_cnt + 4'd1;
        end
        if (last_bit)
          rd_addr_received <= current_state == READ_ADD ? 1'b1 : current_state == READ_DATA ? 1'b0 : rd_addr_received;
        // tx_valid loads the byte; the remaining seven bits follow on successive edges
        if (tx_valid) begin
          miso <= tx_data[7];
          tx_sh <= {tx_data[6:0], 1'b0};
          tx_cnt <= 4'd7;
        end else if (tx_cnt != '0) begin
          miso <= tx_sh[7];
          tx_sh <= {tx_sh[6:0], 1'b0};
          tx_cnt <= tx_cnt - 4'd1;
        end else miso <= 1'b0;
      end
    end
endmodule

// File: rtl/spi_slave_with_ram.sv
// spi_slave_with_ram: SPI slave front end with byte RAM and address registers
// Define RAM_CLR_EN to clear the whole RAM on reset; otherwise RAM contents survive reset.
module spi_slave_with_ram
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);
  logic [7:0] mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr, rx_addr;
  logic [7:0] dout;
  logic tx_valid, rx_valid;
  logic [9:0] rx_data;
  cmd_t cmd;
  assign cmd = cmd_t'(rx_data[9:8]);
  assign rx_addr = ADDR_SIZE'(32'(rx_data[7:0]) % MEM_DEPTH);
  spi_slave_core inst1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .ss_n    (SS_n),
    .mosi    (MOSI),
    .tx_valid(tx_valid),
    .tx_data (dout),
    .miso    (MISO),
    .rx_valid(rx_valid),
    .rx_data (rx_data)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_addr <= '0;
      rd_addr <= '0;
      dout <= '0;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= rx_valid && cmd == CMD_RD_DATA;
      if (rx_valid && cmd == CMD_WR_ADDR) wr_addr <= rx_addr;
      if (rx_valid && cmd == CMD_RD_ADDR) rd_addr <= rx_addr;
      if (rx_valid && cmd == CMD_RD_DATA) dout <= mem[rd_addr];
    end
`ifdef RAM_CLR_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (rx_valid && cmd == CMD_WR_DATA) mem[wr_addr] <= rx_data[7:0];
`else
  always_ff @(posedge clk)
    if (rx_valid && cmd == CMD_WR_DATA) mem[wr_addr] <= rx_data[7:0];
`endif
endmodule

// File: tb/tb_spi_slave_with_ram.sv
// tb_spi_slave_with_ram: randomized frame-level checks against a transaction model of the SPI RAM
module tb_spi_slave_with_ram;
  logic clk = 1'b0, rst_n = 1'b0, SS_n = 1'b1, MOSI = 1'b0;
  logic MISO;
  int checks = 0, failures = 0;
  logic [7:0] m_mem [256];
  logic [7:0] m_wr = '0, m_rd = '0;
  logic m_rcvd = 1'b0;
  spi_slave_with_ram dut (
    .clk  (clk),
    .rst_n(rst_n),
    .SS_n (SS_n),
    .MOSI (MOSI),
    .MISO (MISO)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic xfer(input logic cmd, input logic [9:0] bits, input int nbits);
    logic [7:0] rx;
    logic [2:0] exp_st;
    rx = '0;
    exp_st = !cmd ? 3'd2 : m_rcvd ? 3'd4 : 3'd3;
    SS_n = 1'b0;
    MOSI = 1'b0;
    tick;
    MOSI = cmd;
    tick;
    check("frame_state", dut.inst1.current_state, exp_st);
    for (int i = 9; i > 9 - nbits; i--) begin
      MOSI = bits[i];
      tick;
    end
    if (nbits == 10) begin
      tick;
      tick;
      for (int k = 0; k < 8; k++) begin
        rx = {rx[6:0], MISO};
        tick;
      end
      if (bits[9:8] == 2'b11) check("miso_byte", rx, m_mem[m_rd]);
      else check("miso_quiet", rx, 0);
      if (bits[9:8] == 2'b00) m_wr = bits[7:0];
      if (bits[9:8] == 2'b01) m_mem[m_wr] = bits[7:0];
      if (bits[9:8] == 2'b10) m_rd = bits[7:0];
      if (exp_st == 3'd3) m_rcvd = 1'b1;
      if (exp_st == 3'd4) m_rcvd = 1'b0;
      check("miso_after", MISO, 0);
    end
    SS_n = 1'b1;
    MOSI = 1'b0;
    tick;
    check("state_idle", dut.inst1.current_state, 0);
    check("addr_rcvd", dut.inst1.rd_addr_received, m_rcvd);
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    xfer(1'b0, {2'b00, a}, 10);
    xfer(1'b0, {2'b01, d}, 10);
  endtask
  task automatic rd(input logic [7:0] a);
    xfer(1'b1, {2'b10, a}, 10);
    xfer(1'b1, {2'b11, 8'h00}, 10);
  endtask
  initial begin
    logic [7:0] d, a;
    repeat (3) tick;
    check("rst_miso", MISO, 0);
    check("rst_state", dut.inst1.current_state, 0);
    rst_n = 1'b1;
    tick;
    tick;
    check("idle_miso", MISO, 0);
    check("idle_state", dut.inst1.current_state, 0);
    wr(8'd5, 8'hA5);
    check("mem5_write", dut.mem[5], 8'hA5);
    xfer(1'b1, {2'b10, 8'd5}, 10);
    check("rcvd_set", dut.inst1.rd_addr_received, 1);
    xfer(1'b1, {2'b11, 8'h00}, 10);
    check("rcvd_clr", dut.inst1.rd_addr_received, 0);
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom);
      wr(8'(i), d);
    end
    for (int i = 0; i < 10; i++) rd(8'(i));
    for (int n = 0; n < 6; n++) begin
      a = 8'($urandom);
      d = 8'($urandom);
      wr(a, d);
      rd(a);
    end
    wr(8'd5, 8'hA5);
    xfer(1'b0, {2'b01, 8'h3C}, 5);
    check("abort_mem5", dut.mem[5], 8'hA5);
    xfer(1'b1, {2'b10, 8'd5}, 10);
    SS_n = 1'b0;
    tick;
    MOSI = 1'b1;
    tick;
    check("rd_data_state", dut.inst1.current_state, 4);
    for (int i = 0; i < 10; i++) begin
      MOSI = (i < 2);
      tick;
    end
    tick;
    tick;
    check("miso_bit7", MISO, m_mem[5][7]);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_miso", MISO, 0);
    check("midrst_state", dut.inst1.current_state, 0);
    check("midrst_rcvd", dut.inst1.rd_addr_received, 0);
    m_rcvd = 1'b0;
    m_wr = '0;
    m_rd = '0;
`ifdef RAM_CLR_EN
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
`endif
    @(negedge clk);
    SS_n = 1'b1;
    MOSI = 1'b0;
    rst_n = 1'b1;
    tick;
    rd(8'd5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/spi_slave_with_ram.md
SPI_SLAVE_WITH_RAM -- requirements
Module: spi_slave_with_ram

Interface
REQ-001 SHALL provide parameter MEM_DEPTH, default 256, number of RAM words.
REQ-002 SHALL provide parameter ADDR_SIZE, default 8, RAM address width; word width fixed at 8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port SS_n, input, 1 bit: slave select, active-low frame enable.
REQ-006 SHALL have port MOSI, input, 1 bit: serial data in, MSB first, sampled on the rising edge of clk.
REQ-007 SHALL have port MISO, output, 1 bit: serial read data out, MSB first.

Function
REQ-008 SHALL implement the FSM in the slave sub-module as register current_state with encodings IDLE=0, CHK_CMD=1, WRITE=2, READ_ADD=3, READ_DATA=4.
REQ-009 IDLE->CHK_CMD when SS_n=0; otherwise the FSM stays in IDLE.
REQ-010 In CHK_CMD, sample MOSI as the command bit: 0->WRITE; 1 with rd_addr_received=0->READ_ADD; 1 with rd_addr_received=1->READ_DATA. The command bit is not shifted into rx_data.
REQ-011 In WRITE, READ_ADD and READ_DATA, shift MOSI into rx_data[9:0] MSB first ({rx_data[8:0],MOSI}) on each edge while the 4-bit bit counter is below 10.
REQ-012 After the 10th bit, pulse rx_valid for exactly one cycle with rx_data stable.
REQ-013 On rx_valid, the RAM SHALL decode rx_data[9:8]: 00 stores wr_addr<=rx_data[7:0]; 01 writes mem[wr_addr]<=rx_data[7:0]; 10 stores rd_addr<=rx_data[7:0]; 11 sets dout<=mem[rd_addr] and pulses tx_valid for one cycle.
REQ-014 The RAM SHALL act on rx_data[9:8] regardless of FSM state.
REQ-015 rd_addr_received is set when a READ_ADD frame completes its 10 bits and cleared when a READ_DATA frame completes its 10 bits.
REQ-016 On the edge where tx_valid=1, the slave latches dout. MISO then presents dout[7] and shifts one bit per edge through dout[0] (8 bits). Afterwards MISO returns to 0 and the FSM remains in READ_DATA until SS_n=1.
REQ-017 SS_n=1 in any state SHALL force IDLE on the next edge, clear the bit counter and MISO shift state, and suppress rx_valid; rd_addr_received is unchanged.
REQ-018 SS_n=1 mid-frame (fewer than 10 bits) SHALL cause no RAM access.
REQ-019 Addresses of MEM_DEPTH or more SHALL wrap modulo MEM_DEPTH.
REQ-020 MISO SHALL be 0 whenever no read byte is being shifted out.

Reset
REQ-021 rst_n=0 SHALL immediately set: current_state=IDLE, MISO=0, rx_data=0, rx_valid=0, tx_valid=0, dout=0, wr_addr=0, rd_addr=0, rd_addr_received=0, and both counters=0.
REQ-022 Reset mid-frame SHALL abort the frame with no RAM write.
REQ-023 RAM contents SHALL be unaffected by reset unless RAM_CLR_EN is defined.

Configuration
REQ-024 With macro RAM_CLR_EN defined, rst_n=0 SHALL clear all MEM_DEPTH words to 0x00. Without it, memory SHALL have no reset and power-up contents are undefined.

Structure
REQ-025 Shared package spi_ram_pkg SHALL hold the state typedef and encodings, the command codes (00/01/10/11) and the MEM_DEPTH/ADDR_SIZE defaults.
REQ-026 The slave FSM, shift registers and MISO serializer SHALL be a sub-module spi_slave_core instantiated as inst1. current_state SHALL be hierarchically visible as inst1.current_state.
REQ-027 The RAM array and address registers SHALL be at top level.

Verification
REQ-028 Reset, then SS_n=1 idle: MISO=0 and inst1.current_state=0.
REQ-029 Write frame: SS_n=0, cmd 0, bits 00_00000101; then SS_n=1, SS_n=0, cmd 0, bits 01_10100101. Required: mem[5]=0xA5.
REQ-030 Read frame: SS_n=0, cmd 1, bits 10_00000101, state 3. Then SS_n=1, SS_n=0, cmd 1, bits 11_00000000, state 4. Required: MISO shifts 1,0,1,0,0,1,0,1 (0xA5) and rd_addr_received returns to 0.
REQ-031 Loop over addresses 0..9 with random data: every read returns the written byte.
REQ-032 SS_n=1 after 5 bits of a 01 frame to address 5: mem[5] unchanged (0xA5) and state returns to 0.
REQ-033 rst_n pulsed low in the middle of READ_DATA: MISO=0 immediately and state=0; with RAM_CLR_EN defined, a subsequent read of address 5 returns 0x00.
